uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of rx_bit synchroniser flops, legal 2..4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_bit, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port freq_divider, input, 8 bits: oversample tick period minus one, in clk cycles.
REQ-006 SHALL have port rx_data, output, 8 bits: last good received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle strobe, rx_data is new; drives the RX FIFO push.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle strobe, stop bit sampled low.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL pass rx_bit through SYNC_STAGES flops; all decisions use the last flop, called rxs below.
REQ-011 SHALL run an 8-bit tick counter that asserts tick for one cycle and clears when counter >= freq_divider, else increments: tick period = freq_divider+1 cycles, 16 ticks per bit.
REQ-012 SHALL apply a freq_divider change at the next compare; a lowered value below the current count SHALL tick on the next cycle, with no 256-cycle wrap.
REQ-013 SHALL keep a 4-bit phase counter (0..15) advanced on tick, a 3-bit bit index and an 8-bit shift register.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: on tick with rxs=0 SHALL go to START with phase=0.
REQ-016 START: at the sample point (REQ-022), rxs=0 SHALL go to DATA with bit index=0; rxs=1 SHALL return to IDLE with no strobe (glitch reject).
REQ-017 DATA: on each sample point SHALL shift the sampled bit into position [bit index] (LSB first); after bit 7 SHALL go to STOP.
REQ-018 STOP, sample high: SHALL load rx_data with the shift register, pulse rx_valid the next cycle, and go to IDLE.
REQ-019 STOP, sample low: SHALL pulse frame_err the next cycle, leave rx_data unchanged, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: on tick with rxs=1 SHALL go to IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-021 SHALL never assert rx_valid and frame_err in the same cycle, and SHALL produce at most one strobe per frame.
REQ-022 Sample point = tick at phase 7, measured from the start-detect tick, so each bit is sampled mid-cell; consecutive sample points SHALL be 16 ticks apart.
REQ-023 Because it returns to IDLE at mid-stop, the block SHALL accept a back-to-back start bit immediately after a 1-bit stop.
REQ-024 rx_bit edge to rx_valid latency SHALL be SYNC_STAGES + (9*16+7)*(freq_divider+1) + 1 cycles, within ±1 tick.

Reset
REQ-025 While reset is high, SHALL set: synchroniser flops to 1; state IDLE; tick counter, phase, bit index and shift register to 0; rx_data=0x00; rx_valid=0; frame_err=0; busy=0.
REQ-026 Reset mid-frame SHALL abort the frame with no strobe, and the next falling edge SHALL be treated as a new start bit.

Configuration
REQ-027 Macro RX_MAJORITY_VOTE_EN SHALL select the sampling mode at compile time.
REQ-028 With RX_MAJORITY_VOTE_EN defined: SHALL sample rxs at phases 6, 7 and 8 and use the 2-of-3 majority; the sample point moves to phase 8 and latency in REQ-024 grows by one tick.
REQ-029 Without RX_MAJORITY_VOTE_EN: SHALL use a single sample at phase 7, with no extra registers.

Verification
REQ-030 freq_divider=0, send 0x41 with a good stop bit -> exactly one rx_valid, rx_data=0x41, frame_err never high, busy low after mid-stop.
REQ-031 Back-to-back 0x00, 0xFF, 0xA5 with 1-bit stops, freq_divider=3 -> three rx_valid strobes with rx_data in that order.
REQ-032 rx_bit low for 4 ticks then high -> START returns to IDLE, no rx_valid, no frame_err.
REQ-033 Send 0x55 with stop low, then line held low for 40 ticks -> one frame_err, rx_data keeps its previous value, no new frame until rxs=1.
REQ-034 Reset pulsed during bit 3 of 0xC3, then a full 0x3C sent -> no strobe for 0xC3, rx_valid with rx_data=0x3C.
REQ-035 One-tick high glitch at phase 7 of bit 0 of 0x00 -> rx_data=0x00 with RX_MAJORITY_VOTE_EN, rx_data=0x01 without it.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver front end, 16x oversampled; define RX_MAJORITY_VOTE_EN for 2-of-3 mid-bit voting
module uart_rx_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_divider,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0] cnt, sh, sh_n, data_n;
  logic [3:0] phase, phase_n, phase_p1;
  logic [2:0] bidx, bidx_n;
  logic rxs, tick, samp, bit_s, valid_n, ferr_n;
  assign rxs = sync[SYNC_STAGES-1];
  // compare with >= so a lowered divider ticks at once instead of wrapping
  assign tick = cnt >= freq_divider;
  assign phase_p1 = phase + 4'd1;
  assign busy = state != IDLE;
`ifdef RX_MAJORITY_VOTE_EN
  logic s6, s7;
  assign samp = tick && phase_p1 == 4'd8;
  assign bit_s = (s6 & s7) | (s6 & rxs) | (s7 & rxs);
  always_ff @(posedge clk)
    if (reset) begin
      s6 <= 1'b1;
      s7 <= 1'b1;
    end else if (tick) begin
      if (phase_p1 == 4'd6) s6 <= rxs;
      if (phase_p1 == 4'd7) s7 <= rxs;
    end
`else
  assign samp = tick && phase_p1 == 4'd7;
  assign bit_s = rxs;
`endif
  // phase counts ticks since start detect; the sample tick is the one advancing it to the mid-cell value
  always_comb begin
    state_n = state;
    phase_n = tick ? phase_p1 : phase;
    bidx_n = bidx;
    sh_n = sh;
    data_n = rx_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: if (tick && !rxs) begin
        state_n = START;
        phase_n = '0;
      end
      START: if (samp) begin
        state_n = bit_s ? IDLE : DATA;
        bidx_n = '0;
      end
      DATA: if (samp) begin
        sh_n[bidx] = bit_s;
        bidx_n = bidx + 3'd1;
        if (bidx == 3'd7) state_n = STOP;
      end
      STOP: if (samp) begin
        state_n = bit_s ? IDLE : WAIT_HIGH;
        data_n = bit_s ? sh : rx_data;
        valid_n = bit_s;
        ferr_n = !bit_s;
      end
      WAIT_HIGH: if (tick && rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '1;
      cnt <= '0;
      state <= IDLE;
      phase <= '0;
      bidx <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_bit};
      cnt <= tick ? 8'd0 : cnt + 8'd1;
      state <= state_n;
      phase <= phase_n;
      bidx <= bidx_n;
      sh <= sh_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frame table, multi-cycle corner sequences and randomized frames against a frame-level model
module tb_uart_rx_frontend;
  localparam int S = 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
  localparam logic [7:0] GLITCH_DATA = 8'h00;
`else
  localparam int VOTE = 0;
  localparam logic [7:0] GLITCH_DATA = 8'h01;
`endif
  typedef struct {
    logic [7:0] fd;
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_data;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, rx_bit = 1'b1;
  logic [7:0] freq_divider = 8'd0, rx_data;
  logic rx_valid, frame_err, busy;
  int errors = 0, checks = 0, cyc = 0, n_valid = 0, n_ferr = 0, n_both = 0, valid_cyc = 0, k0 = 0, t = 1;
  logic [7:0] got_q[$];

  uart_rx_frontend #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .freq_divider(freq_divider),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      valid_cyc <= cyc;
      got_q.push_back(rx_data);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid && frame_err) n_both <= n_both + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_latency(input string name);
    int lat, lo, hi;
    lat = valid_cyc - k0;
    lo = S + 151 * t + 1 - t + VOTE * t;
    hi = lo + 2 * t;
    checks++;
    if (lat < lo || lat > hi) begin
      errors++;
      $display("FAIL %s: latency %0d cycles expected %0d..%0d", name, lat, lo, hi);
    end
  endtask

  function automatic logic [31:0] qat(input int k);
    return got_q.size() > k ? {24'd0, got_q[k]} : 32'hDEAD;
  endfunction

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_bit = v;
    end
  endtask

  task automatic set_fd(input int fd);
    freq_divider = 8'(fd);
    t = fd + 1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx_bit = 1'b0;
    k0 = cyc + 1;
    hold(1'b0, 16 * t - 1);
    for (int i = 0; i < 8; i++) hold(d[i], 16 * t);
    hold(stop, 16 * t);
  endtask

  initial begin
    vec_t tbl[6];
    int v0, f0, exp_f;
    logic [7:0] prev, last, cdat;
    logic [7:0] exp_q[$];
    tbl[0] = '{8'd0, 8'h41, 1'b1, 1, 0, 8'h41};
    tbl[1] = '{8'd1, 8'h80, 1'b1, 1, 0, 8'h80};
    tbl[2] = '{8'd5, 8'h7E, 1'b0, 0, 1, 8'h80};
    tbl[3] = '{8'd2, 8'h01, 1'b1, 1, 0, 8'h01};
    tbl[4] = '{8'd7, 8'hFF, 1'b1, 1, 0, 8'hFF};
    tbl[5] = '{8'd3, 8'h00, 1'b0, 0, 1, 8'hFF};
    repeat (4) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;
    hold(1'b1, 8);

    for (int i = 0; i < 6; i++) begin
      set_fd(tbl[i].fd);
      hold(1'b1, 4 * t);
      v0 = n_valid;
      f0 = n_ferr;
      send(tbl[i].data, tbl[i].stop);
      hold(1'b1, 4 * t + S);
      check($sformatf("vec%0d valid count", i), n_valid - v0, tbl[i].exp_v);
      check($sformatf("vec%0d frame_err count", i), n_ferr - f0, tbl[i].exp_f);
      check($sformatf("vec%0d rx_data", i), rx_data, tbl[i].exp_data);
      check($sformatf("vec%0d busy idle", i), busy, 1'b0);
      if (tbl[i].exp_v == 1) check_latency($sformatf("vec%0d latency", i));
    end

    set_fd(3);
    hold(1'b1, 4 * t);
    v0 = n_valid;
    got_q.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    hold(1'b1, 3 * t);
    check("b2b count", n_valid - v0, 3);
    check("b2b byte0", qat(0), 8'h00);
    check("b2b byte1", qat(1), 8'hFF);
    check("b2b byte2", qat(2), 8'hA5);

    v0 = n_valid;
    f0 = n_ferr;
    hold(1'b0, 4 * t);
    check("short start busy", busy, 1'b1);
    hold(1'b1, 30 * t);
    check("short start valid", n_valid - v0, 0);
    check("short start frame_err", n_ferr - f0, 0);
    check("short start idle", busy, 1'b0);

    set_fd(1);
    hold(1'b1, 4 * t);
    prev = rx_data;
    v0 = n_valid;
    f0 = n_ferr;
    send(8'h55, 1'b0);
    hold(1'b0, 40 * t);
    check("break frame_err count", n_ferr - f0, 1);
    check("break valid", n_valid - v0, 0);
    check("break rx_data kept", rx_data, prev);
    check("break busy", busy, 1'b1);
    hold(1'b1, 4 * t + S);
    check("break released idle", busy, 1'b0);
    send(8'h5A, 1'b1);
    hold(1'b1, 3 * t);
    check("after break valid", n_valid - v0, 1);
    check("after break rx_data", rx_data, 8'h5A);
    check("after break frame_err", n_ferr - f0, 1);

    set_fd(2);
    hold(1'b1, 4 * t);
    v0 = n_valid;
    f0 = n_ferr;
    cdat = 8'hC3;
    @(negedge clk);
    rx_bit = 1'b0;
    hold(1'b0, 16 * t - 1);
    for (int i = 0; i < 3; i++) hold(cdat[i], 16 * t);
    hold(cdat[3], 8 * t);
    check("mid-frame busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    rx_bit = 1'b1;
    hold(1'b1, 2);
    check("mid reset busy", busy, 1'b0);
    check("mid reset rx_data", rx_data, 8'h00);
    reset = 1'b0;
    hold(1'b1, 20 * t);
    check("aborted frame valid", n_valid - v0, 0);
    check("aborted frame frame_err", n_ferr - f0, 0);
    send(8'h3C, 1'b1);
    hold(1'b1, 3 * t);
    check("post reset valid", n_valid - v0, 1);
    check("post reset rx_data", rx_data, 8'h3C);

    set_fd(0);
    hold(1'b1, 20);
    v0 = n_valid;
    @(negedge clk);
    rx_bit = 1'b0;
    hold(1'b0, 22);
    hold(1'b1, 1);
    hold(1'b0, 8);
    hold(1'b0, 112);
    hold(1'b1, 20);
    check("glitch valid", n_valid - v0, 1);
    check("glitch rx_data", rx_data, GLITCH_DATA);

    got_q.delete();
    exp_f = n_ferr;
    v0 = n_valid;
    last = rx_data;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] d;
      logic good;
      d = 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      set_fd($urandom_range(0, 3));
      send(d, good);
      if (good) begin
        exp_q.push_back(d);
        last = d;
        hold(1'b1, $urandom_range(0, 3) * t);
      end else begin
        exp_f++;
        hold(1'b1, (2 + $urandom_range(0, 3)) * t + S);
      end
    end
    hold(1'b1, 4 * t + S);
    check("random valid count", n_valid - v0, exp_q.size());
    foreach (exp_q[k]) check($sformatf("random byte%0d", k), qat(k), exp_q[k]);
    check("random frame_err count", n_ferr, exp_f);
    check("random rx_data", rx_data, last);
    check("never both strobes", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
